// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the IF/ID pipeline register.
//   XLEN          : datapath width
//   NOP_INSTR     : canonical bubble instruction (addi x0,x0,0)
//   fetch_state_t : instruction fetch FSM states
//   word_align    : clears the byte-offset bits of an address
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FULL
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus.
//   imem_req_valid  : fetch request valid           (fetch -> memory)
//   imem_req_ready  : memory accepts the request    (memory -> fetch)
//   imem_req_addr   : word address of the request   (fetch -> memory)
//   imem_resp_valid : response word valid           (memory -> fetch)
//   imem_resp_data  : returned instruction word     (memory -> fetch)
// master: fetch stage side; slave: memory side.
interface instr_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall hold and flush-to-NOP.
//   clk, rst   : clock, asynchronous active-high reset
//   stall      : hold all fields
//   flush      : invalidate the slot (wins over stall)
//   load       : capture {load_pc, load_instr} as a valid instruction
//   load_pc    : PC of the incoming instruction
//   load_instr : incoming instruction word
//   valid      : slot holds a real instruction
//   pc         : PC of instr (held across bubbles)
//   instr      : instruction word, NOP_INSTR when invalid
module if_id_reg #(
    parameter logic [cpu_pkg::XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     load,
    input  logic [cpu_pkg::XLEN-1:0] load_pc,
    input  logic [cpu_pkg::XLEN-1:0] load_instr,
    output logic                     valid,
    output logic [cpu_pkg::XLEN-1:0] pc,
    output logic [cpu_pkg::XLEN-1:0] instr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (!stall) begin
            if (load) begin
                valid <= 1'b1;
                pc    <= load_pc;
                instr <= load_instr;
            end else begin
                // Bubble: keep the last PC so debug/trace still sees where we are.
                valid <= 1'b0;
                instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, single-outstanding imem requests,
// a one-entry buffer for a word that arrives while decode is stalled, and the
// IF/ID register.
//   clk, rst       : clock, asynchronous active-high reset
//   imem           : instruction-memory bus (master side)
//   stall          : decode cannot accept; hold IF/ID
//   redirect_valid : taken branch/jump, flush and refetch
//   redirect_pc    : new PC (bits [1:0] forced to 0)
//   if_id_valid    : IF/ID slot holds a real instruction
//   if_id_pc       : PC of if_id_instr
//   if_id_instr    : instruction word to decode
module instr_fetch #(
    parameter logic [cpu_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [cpu_pkg::XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_fetch_if.master            imem,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [cpu_pkg::XLEN-1:0] redirect_pc,
    output logic                     if_id_valid,
    output logic [cpu_pkg::XLEN-1:0] if_id_pc,
    output logic [cpu_pkg::XLEN-1:0] if_id_instr
);

    import cpu_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic            kill_q, kill_d;

    logic            req_fire;
    logic            resp_fire;
    logic            load;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] load_instr;

    assign imem.imem_req_valid = (state_q == REQ);
    assign imem.imem_req_addr  = pc_q;

    assign req_fire  = (state_q == REQ) && imem.imem_req_ready;
    // Responses outside WAIT are protocol violations and are ignored.
    assign resp_fire = (state_q == WAIT) && imem.imem_resp_valid;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        buf_pc_d      = buf_pc_q;
        buf_instr_d   = buf_instr_q;
        kill_d        = kill_q;
        load          = 1'b0;
        load_pc       = inflight_pc_q;
        load_instr    = imem.imem_resp_data;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req_fire) begin
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + 32'd4;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (resp_fire) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else if (!stall) begin
                        load    = 1'b1;
                        state_d = REQ;
                    end else begin
                        buf_pc_d    = inflight_pc_q;
                        buf_instr_d = imem.imem_resp_data;
                        state_d     = FULL;
                    end
                end
            end
            FULL: begin
                if (!stall) begin
                    load       = 1'b1;
                    load_pc    = buf_pc_q;
                    load_instr = buf_instr_q;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything above, including stall.
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
            load = 1'b0;
            case (state_q)
                REQ: begin
                    // An accepted old address still owes us a response; drop it.
                    if (req_fire) begin
                        state_d = WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
                WAIT: begin
                    if (resp_fire) begin
                        state_d = REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= word_align(RESET_PC);
            inflight_pc_q <= '0;
            buf_pc_q      <= '0;
            buf_instr_q   <= NOP_INSTR;
            kill_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            buf_pc_q      <= buf_pc_d;
            buf_instr_q   <= buf_instr_d;
            kill_q        <= kill_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (redirect_valid),
        .load       (load),
        .load_pc    (load_pc),
        .load_instr (load_instr),
        .valid      (if_id_valid),
        .pc         (if_id_pc),
        .instr      (if_id_instr)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. A small memory model answers each accepted
// request after a programmable latency with addr ^ 32'hA5A5_0000. Outputs are
// checked on the falling edge against hand-computed values.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    instr_fetch_if mif ();

    instr_fetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (mif.master),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr)
    );

    localparam logic [31:0] Nop  = 32'h0000_0013;
    localparam logic [31:0] Salt = 32'hA5A5_0000;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check_eq({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
        check_eq({tag, "_pc"}, if_id_pc, pc);
        check_eq({tag, "_instr"}, if_id_instr, instr);
    endtask

    task automatic check_req(input string tag, input logic valid, input logic [31:0] addr);
        check_eq({tag, "_req_valid"}, {31'd0, mif.imem_req_valid}, {31'd0, valid});
        if (valid) check_eq({tag, "_req_addr"}, mif.imem_req_addr, addr);
    endtask

    // Memory model: sample the request late in the low phase, answer after posedge.
    initial begin
        bit          acc;
        bit          pend;
        int          cnt;
        logic [31:0] acc_addr;
        logic [31:0] paddr;
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        mif.imem_resp_valid = 1'b0;
        mif.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            #3;
            acc      = mif.imem_req_valid && mif.imem_req_ready;
            acc_addr = mif.imem_req_addr;
            @(posedge clk);
            #1;
            mif.imem_resp_valid = 1'b0;
            if (acc) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = acc_addr;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mif.imem_resp_valid = 1'b1;
                    mif.imem_resp_data  = paddr ^ Salt;
                    pend = 1'b0;
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mif.imem_req_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_req("rst", 1'b0, 32'h0);
        check_eq("rst_addr", mif.imem_req_addr, 32'h0);
        check_eq("rst_if_valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("rst_if_pc", if_id_pc, 32'h0);
        check_eq("rst_if_instr", if_id_instr, Nop);
        rst = 1'b0;

        // Straight-line fetch, 1-cycle memory.
        @(negedge clk); check_req("first", 1'b1, 32'h0);
        check_eq("first_if_valid", {31'd0, if_id_valid}, 32'd0);
        @(negedge clk); check_req("wait0", 1'b0, 32'h0);
        @(negedge clk); check_slot("slot0", 32'h0, 32'hA5A5_0000);
        check_req("req4", 1'b1, 32'h4);
        @(negedge clk); check_eq("bubble_valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("bubble_instr", if_id_instr, Nop);
        @(negedge clk); check_slot("slot4", 32'h4, 32'hA5A5_0004);

        // Stall across the 0x8 response: buffer it, issue nothing.
        stall = 1'b1;
        @(negedge clk); check_slot("hold6", 32'h4, 32'hA5A5_0004);
        check_req("hold6", 1'b0, 32'h0);
        @(negedge clk); check_req("full7", 1'b0, 32'h0);
        @(negedge clk); check_req("full8", 1'b0, 32'h0);
        @(negedge clk); check_slot("hold9", 32'h4, 32'hA5A5_0004);
        check_req("full9", 1'b0, 32'h0);
        stall = 1'b0;
        @(negedge clk); check_slot("unbuf8", 32'h8, 32'hA5A5_0008);
        check_req("reqC", 1'b1, 32'hC);
        @(negedge clk);
        @(negedge clk); check_slot("slotC", 32'hC, 32'hA5A5_000C);

        // Redirect while waiting (3-cycle latency) for 0x10.
        lat = 3;
        @(negedge clk); check_req("wait10", 1'b0, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk); redirect_valid = 1'b0;
        check_req("kill_wait", 1'b0, 32'h0);
        check_eq("kill_wait_pc", mif.imem_req_addr, 32'h100);
        check_eq("kill_wait_if", {31'd0, if_id_valid}, 32'd0);
        @(negedge clk); check_req("kill_wait2", 1'b0, 32'h0);
        @(negedge clk); check_req("req100", 1'b1, 32'h100);
        check_eq("drop10_if", {31'd0, if_id_valid}, 32'd0);
        lat = 1;
        @(negedge clk); check_eq("wait100_if", {31'd0, if_id_valid}, 32'd0);
        @(negedge clk); check_slot("slot100", 32'h100, 32'hA5A5_0100);
        check_req("req104", 1'b1, 32'h104);

        // Redirect coinciding with acceptance of 0x104.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        lat = 2;
        @(negedge clk); redirect_valid = 1'b0;
        check_req("acc_kill", 1'b0, 32'h0);
        check_eq("acc_kill_if_valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("acc_kill_if_instr", if_id_instr, Nop);
        check_eq("acc_kill_if_pc", if_id_pc, 32'h100);
        @(negedge clk); check_req("acc_kill2", 1'b0, 32'h0);
        @(negedge clk); check_req("req200", 1'b1, 32'h200);
        check_eq("drop104_if", {31'd0, if_id_valid}, 32'd0);
        lat = 1;
        @(negedge clk);
        @(negedge clk); check_slot("slot200", 32'h200, 32'hA5A5_0200);

        // Redirect while stalled in FULL.
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk); check_req("full204", 1'b0, 32'h0);
        check_slot("hold200", 32'h200, 32'hA5A5_0200);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(negedge clk); redirect_valid = 1'b0;
        check_eq("full_flush_valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("full_flush_instr", if_id_instr, Nop);
        check_req("req300", 1'b1, 32'h300);
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk); check_slot("slot300", 32'h300, 32'hA5A5_0300);

        // PC wrap: redirect without handshake, then fetch the last word.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        mif.imem_req_ready = 1'b0;
        @(negedge clk); redirect_valid = 1'b0;
        mif.imem_req_ready = 1'b1;
        check_req("reqTop", 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk); check_slot("slotTop", 32'hFFFF_FFFC, 32'h5A5A_FFFC);
        check_req("wrap", 1'b1, 32'h0);

        // Asynchronous reset mid-WAIT; the late response must be ignored.
        lat = 3;
        @(negedge clk); check_req("wait0b", 1'b0, 32'h0);
        check_eq("wait0b_pc", mif.imem_req_addr, 32'h4);
        #2 rst = 1'b1;
        #1;
        check_req("arst", 1'b0, 32'h0);
        check_eq("arst_addr", mif.imem_req_addr, 32'h0);
        check_eq("arst_if_valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("arst_if_pc", if_id_pc, 32'h0);
        check_eq("arst_if_instr", if_id_instr, Nop);
        @(negedge clk); rst = 1'b0;
        check_req("arst_idle", 1'b0, 32'h0);
        @(negedge clk); check_req("arst_req", 1'b1, 32'h0);
        lat = 1;
        @(negedge clk); check_eq("late_resp_if", {31'd0, if_id_valid}, 32'd0);
        check_req("late_wait", 1'b0, 32'h0);
        @(negedge clk); check_slot("slot0b", 32'h0, 32'hA5A5_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
